// File: rtl/matrix_scan.sv
// HUB75 64x32 1/16-scan driver: fetches RGB565 pixels from the framebuffer and shifts 6-plane BCM data.
// Optional MATRIX_SCAN_TESTPATTERN_EN adds a test_pattern input that replaces RAM data with a column/row ramp.
module matrix_scan #(
   parameter int COLS        = 64,
   parameter int BASE_TICKS  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [2:0]  rgb_enable,
   input  logic [5:0]  brightness_enable,
`ifdef MATRIX_SCAN_TESTPATTERN_EN
   input  logic        test_pattern,
`endif
   input  logic [7:0]  ram_data_in,
   output logic [11:0] ram_address,
   output logic        ram_clk_enable,
   output logic        panel_r1,
   output logic        panel_g1,
   output logic        panel_b1,
   output logic        panel_r2,
   output logic        panel_g2,
   output logic        panel_b2,
   output logic        panel_clk,
   output logic        panel_latch,
   output logic        panel_oe_n,
   output logic [3:0]  panel_row,
   output logic        frame_start
);

   // IDLE only holds the outputs quiet for the single cycle after reset before START.
   typedef enum logic [2:0] {IDLE, START, FETCH, SHIFT, LATCH, DISPLAY} state_t;

   state_t      state;
   logic [2:0]  fcnt;
   logic [3:0]  row;
   logic [2:0]  plane;
   logic [5:0]  col;
   logic [15:0] tick;
   logic [2:0]  rgb_w;
   logic [5:0]  bri_w;
   logic [7:0]  hi_u, lo_u, hi_l;
   logic [5:0]  pix;
   logic        fetch_ce;

   logic [8:0]  sync_q [SYNC_STAGES];

   // Plain synchronizer chain; no reset so it keeps tracking while reset is held.
   always_ff @(posedge clk_in) begin
      sync_q[0] <= {brightness_enable, rgb_enable};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
   end

`ifdef MATRIX_SCAN_TESTPATTERN_EN
   logic tp_w;
   assign fetch_ce = ~tp_w;
`else
   assign fetch_ce = 1'b1;
`endif

   always_comb begin
      logic [15:0] w_u, w_l;
      logic [5:0]  ru, gu, bu, rl, gl, bl;
      w_u = {hi_u, lo_u};
      w_l = {hi_l, ram_data_in};
      ru = {w_u[15:11], w_u[15]};
      gu = w_u[10:5];
      bu = {w_u[4:0], w_u[4]};
      rl = {w_l[15:11], w_l[15]};
      gl = w_l[10:5];
      bl = {w_l[4:0], w_l[4]};
`ifdef MATRIX_SCAN_TESTPATTERN_EN
      if (tp_w) begin
         ru = col;
         gu = ~col;
         bu = {row, 2'b00};
         rl = ru;
         gl = gu;
         bl = bu;
      end
`endif
      pix = {ru[plane] & rgb_w[0], gu[plane] & rgb_w[1], bu[plane] & rgb_w[2],
             rl[plane] & rgb_w[0], gl[plane] & rgb_w[1], bl[plane] & rgb_w[2]}
            & {6{bri_w[plane]}};
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         fcnt           <= '0;
         row            <= '0;
         plane          <= '0;
         col            <= '0;
         tick           <= '0;
         rgb_w          <= '0;
         bri_w          <= '0;
         hi_u           <= '0;
         lo_u           <= '0;
         hi_l           <= '0;
         ram_address    <= '0;
         ram_clk_enable <= 1'b0;
         {panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2} <= '0;
         panel_clk      <= 1'b0;
         panel_latch    <= 1'b0;
         panel_oe_n     <= 1'b1;
         panel_row      <= '0;
         frame_start    <= 1'b0;
`ifdef MATRIX_SCAN_TESTPATTERN_EN
         tp_w           <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state       <= START;
               frame_start <= 1'b1;
            end
            START: begin
               frame_start    <= 1'b0;
               rgb_w          <= sync_q[SYNC_STAGES-1][2:0];
               bri_w          <= sync_q[SYNC_STAGES-1][8:3];
`ifdef MATRIX_SCAN_TESTPATTERN_EN
               tp_w           <= test_pattern;
               ram_clk_enable <= ~test_pattern;
`else
               ram_clk_enable <= 1'b1;
`endif
               row            <= '0;
               plane          <= '0;
               col            <= '0;
               fcnt           <= '0;
               ram_address    <= {1'b0, 4'd0, 6'd0, 1'b1};
               state          <= FETCH;
            end
            FETCH: begin
               fcnt <= fcnt + 3'd1;
               case (fcnt)
                  3'd0: ram_address <= {1'b0, row, col, 1'b0};
                  3'd1: begin
                     hi_u        <= ram_data_in;
                     ram_address <= {1'b1, row, col, 1'b1};
                  end
                  3'd2: begin
                     lo_u        <= ram_data_in;
                     ram_address <= {1'b1, row, col, 1'b0};
                  end
                  3'd3: begin
                     hi_l           <= ram_data_in;
                     ram_clk_enable <= 1'b0;
                  end
                  default: begin
                     {panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2} <= pix;
                     panel_clk <= 1'b1;
                     state     <= SHIFT;
                  end
               endcase
            end
            SHIFT: begin
               panel_clk <= 1'b0;
               if (col == 6'(COLS - 1)) begin
                  panel_latch <= 1'b1;
                  panel_row   <= row;
                  state       <= LATCH;
               end else begin
                  col            <= col + 6'd1;
                  fcnt           <= '0;
                  ram_clk_enable <= fetch_ce;
                  ram_address    <= {1'b0, row, col + 6'd1, 1'b1};
                  state          <= FETCH;
               end
            end
            LATCH: begin
               panel_latch <= 1'b0;
               panel_oe_n  <= 1'b0;
               col         <= '0;
               tick        <= (16'(BASE_TICKS) << plane) - 16'd1;
               state       <= DISPLAY;
            end
            DISPLAY: begin
               if (tick != 16'd0) begin
                  tick <= tick - 16'd1;
               end else begin
                  panel_oe_n <= 1'b1;
                  fcnt       <= '0;
                  if (plane != 3'd5) begin
                     plane          <= plane + 3'd1;
                     ram_clk_enable <= fetch_ce;
                     ram_address    <= {1'b0, row, 6'd0, 1'b1};
                     state          <= FETCH;
                  end else if (row != 4'd15) begin
                     plane          <= '0;
                     row            <= row + 4'd1;
                     ram_clk_enable <= fetch_ce;
                     ram_address    <= {1'b0, row + 4'd1, 6'd0, 1'b1};
                     state          <= FETCH;
                  end else begin
                     plane       <= '0;
                     row         <= '0;
                     frame_start <= 1'b1;
                     state       <= START;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/matrix_scan.md
Name: matrix_scan

Overview:
- Downstream consumer of the line-command framebuffer.
- Reads pixel bytes from the read port of the 4096x8 dual-port framebuffer RAM.
- Drives a 64x32, 1/16-scan HUB75 panel using 6-plane binary-coded modulation (BCM), gated by the rgb_enable and brightness_enable control masks.
- Sits between the framebuffer RAM and the panel connector pins.

Parameters:
- COLS, 64, pixels per shifted line; 6-bit column field.
- BASE_TICKS, 8, clk_in cycles OE is active for plane 0; plane p is active for BASE_TICKS<<p.
- SYNC_STAGES, 2, flop stages on rgb_enable/brightness_enable.

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high
- rgb_enable  input  3  bit0 R, bit1 G, bit2 B channel enables (foreign domain)
- brightness_enable  input  6  per-plane enable, bit p = plane p (foreign domain)
- ram_data_in  input  8  framebuffer read data, valid 1 cycle after ram_address
- ram_address  output  12  {row[4:0], col[5:0], byte_sel}; byte_sel 1 = high byte
- ram_clk_enable  output  1  read strobe
- panel_r1, panel_g1, panel_b1  output  1 each  upper-half data (rows 0-15)
- panel_r2, panel_g2, panel_b2  output  1 each  lower-half data (rows 16-31)
- panel_clk  output  1  shift clock
- panel_latch  output  1  latch strobe
- panel_oe_n  output  1  output enable, active-low
- panel_row  output  4  scanned row address
- frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- Reset values: panel_oe_n=1; all other outputs 0. Reset asserted mid-operation aborts immediately to these values; after release, the block restarts at row 0, plane 0, col 0.
- Pixel format is RGB565, word = {hi, lo}. Channels are widened to 6 bits: R6={R5,R5[4]}, G6=G6, B6={B5,B5[4]}.
- For plane p, channel bit = chan6[p] & rgb_enable_sync[ch] & brightness_enable_sync[p].
- Enables pass through SYNC_STAGES flops, then are captured into working registers only in the cycle frame_start=1. Mid-frame changes take effect on the next frame.
- States: START, FETCH, SHIFT, LATCH, DISPLAY.
- START (1 cycle):
  - frame_start=1; capture enables; row=0, plane=0, col=0.
  - Next state: FETCH.
- FETCH (5 cycles, f=0..4):
  - f=0..3: ram_clk_enable=1; ram_address in order {0,r,col,1}, {0,r,col,0}, {1,r,col,1}, {1,r,col,0}.
  - f=1..4: capture the byte returned for address f-1.
  - At end of f=4, panel_r1..b2 are updated.
  - Next state: SHIFT.
- SHIFT (1 cycle):
  - panel_clk=1 with data stable.
  - If col==COLS-1, next state is LATCH; else col+1 and back to FETCH.
  - Total per column: 6 cycles. Per plane: 384 shift cycles.
- LATCH (1 cycle):
  - panel_oe_n=1, panel_latch=1, panel_row<=row (updated in this cycle).
  - Next state: DISPLAY.
- DISPLAY:
  - panel_oe_n=0 for exactly BASE_TICKS<<plane cycles; 16-bit down-counter.
  - Then oe_n=1 and plane+1.
  - If plane was 5: plane=0 and row+1.
  - If row was 15: next state is START (wrap); else FETCH with col=0.
- panel_oe_n is always 1 outside DISPLAY, so the panel is blanked during shift and latch.
- panel_clk and panel_latch are never both 1.
- ram_clk_enable is 0 outside FETCH f=0..3.
- Width rules: column counter wraps only through LATCH; row is a 4-bit counter with explicit wrap at 15.

Optional Feature:
- Macro: MATRIX_SCAN_TESTPATTERN_EN.
- Defined: adds input port test_pattern (1 bit, sampled at frame_start).
  - When set, ram_data_in is ignored: R6=col[5:0], G6=~col[5:0], B6={row[3:0],2'b00} for both halves.
  - ram_clk_enable is held 0; FETCH timing is unchanged.
- Undefined: no port, and RAM data is always used.

Test Plan:
- Write RAM {0,0,0,1}=8'hFF and {0,0,0,0}=8'hFF; all enables 1. Expect r1=g1=b1=1 on the first panel_clk of every plane at row 0; r2=g2=b2=0.
- Pixel at row 20, col 3 = 16'hF800. Expect r2=1 only on the 4th panel_clk, only when panel_row=4, all 6 planes; g2=b2=0.
- rgb_enable=3'b101, brightness_enable=6'b000001, white pixel. Expect g1=0 always; r1=b1=1 only in plane 0.
- Measure panel_oe_n low durations with BASE_TICKS=8. Expect 8, 16, 32, 64, 128, 256 cycles per row. Check 384 cycles from frame_start+1 to the first panel_latch.
- Toggle rgb_enable mid-frame. Expect outputs unchanged until after the next frame_start plus sync delay.
- Assert reset during SHIFT at col 30. Expect immediate oe_n=1 and all else 0; after release, the first fetch address is 12'h001.
